// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage: RV32I instruction decode with register file and ID/EX register.
//
// Decodes instrD into control signals and a sign-extended immediate, reads the
// two source operands from a 32 x 32-bit register file (with write-through
// bypass from writeback), and captures everything into the ID/EX pipeline
// register on each rising clock edge.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   instrD, pcD, pc4D          instruction (32'h0 = bubble) and its PC / PC+4
//   flushE                     squash the ID/EX register on the next edge
//   regWriteW, rdW, resultW    writeback port into the register file
//   rs1D, rs2D                 combinational source indices for the hazard unit
//   *E outputs                 registered decode results and operands
// ---------------------------------------------------------------------------
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instrD,
    input  logic [31:0] pcD,
    input  logic [31:0] pc4D,
    input  logic        flushE,
    input  logic        regWriteW,
    input  logic [4:0]  rdW,
    input  logic [31:0] resultW,
    output logic [4:0]  rs1D,
    output logic [4:0]  rs2D,
    output logic        regWriteE,
    output logic        memWriteE,
    output logic        branchE,
    output logic        jumpE,
    output logic        jalrE,
    output logic        aluSrcBE,
    output logic        illegalE,
    output logic [1:0]  resultSrcE,
    output logic [1:0]  aluSrcAE,
    output logic [3:0]  aluControlE,
    output logic [2:0]  funct3E,
    output logic [31:0] rd1E,
    output logic [31:0] rd2E,
    output logic [31:0] immExtE,
    output logic [31:0] pcE,
    output logic [31:0] pc4E,
    output logic [4:0]  rs1E,
    output logic [4:0]  rs2E,
    output logic [4:0]  rdE
);

    typedef enum logic [3:0] {
        AluAdd  = 4'b0000,
        AluSub  = 4'b0001,
        AluAnd  = 4'b0010,
        AluOr   = 4'b0011,
        AluXor  = 4'b0100,
        AluSll  = 4'b0101,
        AluSrl  = 4'b0110,
        AluSra  = 4'b0111,
        AluSlt  = 4'b1000,
        AluSltu = 4'b1001
    } aluOp_t;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } immSel_t;

    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rdD;

    assign opcode   = instrD[6:0];
    assign funct3   = instrD[14:12];
    assign funct7b5 = instrD[30];
    assign rdD      = instrD[11:7];
    assign rs1D     = instrD[19:15];
    assign rs2D     = instrD[24:20];

    // Main control decode
    logic      regWriteD;
    logic      memWriteD;
    logic      branchD;
    logic      jumpD;
    logic      jalrD;
    logic      aluSrcBD;
    logic      illegalD;
    logic [1:0] resultSrcD;
    logic [1:0] aluSrcAD;
    logic      useAluFunct;
    logic      isRType;
    immSel_t   immSel;
    aluOp_t    aluOpD;

    always_comb begin
        regWriteD   = 1'b0;
        memWriteD   = 1'b0;
        branchD     = 1'b0;
        jumpD       = 1'b0;
        jalrD       = 1'b0;
        aluSrcBD    = 1'b0;
        illegalD    = 1'b0;
        resultSrcD  = 2'b00;
        aluSrcAD    = 2'b00;
        useAluFunct = 1'b0;
        isRType     = 1'b0;
        immSel      = ImmNone;
        case (opcode)
            OpRType: begin
                regWriteD   = 1'b1;
                useAluFunct = 1'b1;
                isRType     = 1'b1;
            end
            OpIAlu: begin
                regWriteD   = 1'b1;
                aluSrcBD    = 1'b1;
                useAluFunct = 1'b1;
                immSel      = ImmI;
            end
            OpLoad: begin
                regWriteD  = 1'b1;
                aluSrcBD   = 1'b1;
                resultSrcD = 2'b01;
                immSel     = ImmI;
            end
            OpStore: begin
                memWriteD = 1'b1;
                aluSrcBD  = 1'b1;
                immSel    = ImmS;
            end
            OpBranch: begin
                branchD = 1'b1;
                immSel  = ImmB;
            end
            OpJal: begin
                jumpD      = 1'b1;
                regWriteD  = 1'b1;
                resultSrcD = 2'b10;
                immSel     = ImmJ;
            end
            OpJalr: begin
                jalrD      = 1'b1;
                regWriteD  = 1'b1;
                resultSrcD = 2'b10;
                aluSrcBD   = 1'b1;
                immSel     = ImmI;
            end
            OpLui: begin
                regWriteD = 1'b1;
                aluSrcAD  = 2'b10;
                aluSrcBD  = 1'b1;
                immSel    = ImmU;
            end
            OpAuipc: begin
                regWriteD = 1'b1;
                aluSrcAD  = 2'b01;
                aluSrcBD  = 1'b1;
                immSel    = ImmU;
            end
            default: begin
                // An all-zero word is a pipeline bubble, not an illegal instruction.
                illegalD = (instrD != 32'h0);
            end
        endcase
    end

    // ALU operation: funct3-driven for R/I-ALU, SUB for branches, ADD otherwise.
    always_comb begin
        aluOpD = AluAdd;
        if (branchD) begin
            aluOpD = AluSub;
        end else if (useAluFunct) begin
            case (funct3)
                3'b000:  aluOpD = (isRType && funct7b5) ? AluSub : AluAdd;
                3'b001:  aluOpD = AluSll;
                3'b010:  aluOpD = AluSlt;
                3'b011:  aluOpD = AluSltu;
                3'b100:  aluOpD = AluXor;
                3'b101:  aluOpD = funct7b5 ? AluSra : AluSrl;
                3'b110:  aluOpD = AluOr;
                default: aluOpD = AluAnd;
            endcase
        end
    end

    // Immediate generation
    logic [31:0] immExtD;

    always_comb begin
        immExtD = 32'h0;
        case (immSel)
            ImmI: immExtD = {{20{instrD[31]}}, instrD[31:20]};
            ImmS: immExtD = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
            ImmB: immExtD = {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
            ImmU: immExtD = {instrD[31:12], 12'h0};
            ImmJ: immExtD = {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
            default: immExtD = 32'h0;
        endcase
    end

    // Register file
    logic [31:0] regs [32];
    logic [31:0] rd1D;
    logic [31:0] rd2D;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (regWriteW && (rdW != 5'd0)) begin
            regs[rdW] <= resultW;
        end
    end

    // Write-through bypass so a same-cycle writeback is visible to decode.
    always_comb begin
        if (rs1D == 5'd0) begin
            rd1D = 32'h0;
        end else if (regWriteW && (rdW == rs1D)) begin
            rd1D = resultW;
        end else begin
            rd1D = regs[rs1D];
        end
        if (rs2D == 5'd0) begin
            rd2D = 32'h0;
        end else if (regWriteW && (rdW == rs2D)) begin
            rd2D = resultW;
        end else begin
            rd2D = regs[rs2D];
        end
    end

    // ID/EX pipeline register; reset and flush both insert a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || flushE) begin
            regWriteE   <= 1'b0;
            memWriteE   <= 1'b0;
            branchE     <= 1'b0;
            jumpE       <= 1'b0;
            jalrE       <= 1'b0;
            aluSrcBE    <= 1'b0;
            illegalE    <= 1'b0;
            resultSrcE  <= 2'b00;
            aluSrcAE    <= 2'b00;
            aluControlE <= 4'b0000;
            funct3E     <= 3'b000;
            rd1E        <= 32'h0;
            rd2E        <= 32'h0;
            immExtE     <= 32'h0;
            pcE         <= 32'h0;
            pc4E        <= 32'h0;
            rs1E        <= 5'd0;
            rs2E        <= 5'd0;
            rdE         <= 5'd0;
        end else begin
            regWriteE   <= regWriteD;
            memWriteE   <= memWriteD;
            branchE     <= branchD;
            jumpE       <= jumpD;
            jalrE       <= jalrD;
            aluSrcBE    <= aluSrcBD;
            illegalE    <= illegalD;
            resultSrcE  <= resultSrcD;
            aluSrcAE    <= aluSrcAD;
            aluControlE <= aluOpD;
            funct3E     <= funct3;
            rd1E        <= rd1D;
            rd2E        <= rd2D;
            immExtE     <= immExtD;
            pcE         <= pcD;
            pc4E        <= pc4D;
            rs1E        <= rs1D;
            rs2E        <= rs2D;
            rdE         <= rdD;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage: directed and randomized checks of decode_stage against a
// behavioural model (instruction-table decode plus an array register file).
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instrD, pcD, pc4D;
    logic        flushE, regWriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    logic [4:0]  rs1D, rs2D;
    logic        regWriteE, memWriteE, branchE, jumpE, jalrE, aluSrcBE, illegalE;
    logic [1:0]  resultSrcE, aluSrcAE;
    logic [3:0]  aluControlE;
    logic [2:0]  funct3E;
    logic [31:0] rd1E, rd2E, immExtE, pcE, pc4E;
    logic [4:0]  rs1E, rs2E, rdE;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [32];
    logic [192:0] expVec;
    logic [192:0] obsVec;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .instrD(instrD), .pcD(pcD), .pc4D(pc4D),
        .flushE(flushE), .regWriteW(regWriteW), .rdW(rdW), .resultW(resultW),
        .rs1D(rs1D), .rs2D(rs2D), .regWriteE(regWriteE), .memWriteE(memWriteE),
        .branchE(branchE), .jumpE(jumpE), .jalrE(jalrE), .aluSrcBE(aluSrcBE),
        .illegalE(illegalE), .resultSrcE(resultSrcE), .aluSrcAE(aluSrcAE),
        .aluControlE(aluControlE), .funct3E(funct3E), .rd1E(rd1E), .rd2E(rd2E),
        .immExtE(immExtE), .pcE(pcE), .pc4E(pc4E), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE)
    );

    assign obsVec = {regWriteE, memWriteE, branchE, jumpE, jalrE, aluSrcBE, illegalE,
                     resultSrcE, aluSrcAE, aluControlE, funct3E, rd1E, rd2E, immExtE,
                     pcE, pc4E, rs1E, rs2E, rdE};

    task automatic check(input string tag, input logic [192:0] obs, input logic [192:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ALU code by funct3 for the register/immediate arithmetic group.
    function automatic logic [3:0] aluRef(input logic [2:0] f3, input logic alt,
                                          input logic isR);
        logic [3:0] tbl [8];
        tbl[0] = 4'd0; tbl[1] = 4'd5; tbl[2] = 4'd8; tbl[3] = 4'd9;
        tbl[4] = 4'd4; tbl[5] = 4'd6; tbl[6] = 4'd3; tbl[7] = 4'd2;
        if (f3 == 3'd0 && isR && alt) return 4'd1;
        if (f3 == 3'd5 && alt) return 4'd7;
        return tbl[f3];
    endfunction

    function automatic logic [192:0] refDecode(input logic [31:0] ins, input logic [31:0] pc,
                                               input logic [31:0] pc4, input logic [31:0] a,
                                               input logic [31:0] b);
        logic rw, mw, br, jp, jr, sb, ill;
        logic [1:0] rsel, sa;
        logic [3:0] alu;
        logic [31:0] imm;
        rw = 0; mw = 0; br = 0; jp = 0; jr = 0; sb = 0; ill = 0;
        rsel = 0; sa = 0; alu = 0; imm = 0;
        case (ins[6:0])
            7'h33: begin rw = 1; alu = aluRef(ins[14:12], ins[30], 1'b1); end
            7'h13: begin
                rw = 1; sb = 1; alu = aluRef(ins[14:12], ins[30], 1'b0);
                imm = $signed(ins[31:20]);
            end
            7'h03: begin rw = 1; sb = 1; rsel = 1; imm = $signed(ins[31:20]); end
            7'h23: begin mw = 1; sb = 1; imm = $signed({ins[31:25], ins[11:7]}); end
            7'h63: begin
                br = 1; alu = 4'd1;
                imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            end
            7'h6F: begin
                jp = 1; rw = 1; rsel = 2;
                imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            end
            7'h67: begin jr = 1; rw = 1; rsel = 2; sb = 1; imm = $signed(ins[31:20]); end
            7'h37: begin rw = 1; sa = 2; sb = 1; imm = ins & 32'hFFFFF000; end
            7'h17: begin rw = 1; sa = 1; sb = 1; imm = ins & 32'hFFFFF000; end
            default: ill = (ins != 0);
        endcase
        return {rw, mw, br, jp, jr, sb, ill, rsel, sa, alu, ins[14:12], a, b, imm,
                pc, pc4, ins[19:15], ins[24:20], ins[11:7]};
    endfunction

    function automatic logic [31:0] readRef(input logic [4:0] idx, input logic wr,
                                            input logic [4:0] rdw, input logic [31:0] res);
        if (idx == 0) return 32'h0;
        if (wr && rdw == idx) return res;
        return model[idx];
    endfunction

    // One clock: drive at negedge, check combinational indices, clock, check E outputs.
    task automatic step(input logic rst, input logic [31:0] ins, input logic fl,
                        input logic wr, input logic [4:0] rdw, input logic [31:0] res);
        logic [31:0] pc;
        @(negedge clk);
        pc = $urandom & 32'hFFFFFFFC;
        rst_n = rst; instrD = ins; flushE = fl; regWriteW = wr; rdW = rdw; resultW = res;
        pcD = pc; pc4D = pc + 4;
        #1;
        check("rs1D", 193'(rs1D), 193'(ins[19:15]));
        check("rs2D", 193'(rs2D), 193'(ins[24:20]));
        if (!rst || fl) expVec = '0;
        else expVec = refDecode(ins, pc, pc + 4, readRef(ins[19:15], wr, rdw, res),
                                readRef(ins[24:20], wr, rdw, res));
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = 0;
        end else if (wr && rdw != 0) begin
            model[rdw] = res;
        end
        #1;
        check("idex", obsVec, expVec);
    endtask

    logic [6:0] opcs [9];

    initial begin
        logic [31:0] ins;
        int sel;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        for (int i = 0; i < 32; i++) model[i] = 0;
        rst_n = 0; instrD = 0; pcD = 0; pc4D = 0; flushE = 0;
        regWriteW = 0; rdW = 0; resultW = 0;

        // Reset overrides flush and writeback.
        step(0, 32'h00500093, 1, 1, 5, 32'h12345678);
        step(0, 32'h00500093, 0, 0, 0, 0);
        check("rst.regWrite", 193'(regWriteE), 193'(0));
        check("rst.rd1", 193'(rd1E), 193'(0));

        // addi x1,x0,5
        step(1, 32'h00500093, 0, 0, 0, 0);
        check("addi.regWrite", 193'(regWriteE), 193'(1));
        check("addi.aluSrcB", 193'(aluSrcBE), 193'(1));
        check("addi.imm", 193'(immExtE), 193'(5));
        check("addi.rd", 193'(rdE), 193'(1));
        check("addi.alu", 193'(aluControlE), 193'(0));

        // add x4,x3,x0 while writing x3: bypass
        step(1, 32'h00018233, 0, 1, 3, 32'hDEADBEEF);
        check("bypass.rd1", 193'(rd1E), 193'(32'hDEADBEEF));
        step(1, 32'h00018233, 0, 0, 0, 0);
        check("stored.rd1", 193'(rd1E), 193'(32'hDEADBEEF));

        // x0 write is dropped
        step(1, 32'h00000033, 0, 1, 0, 32'h0BADF00D);
        check("x0.bypass", 193'(rd1E), 193'(0));
        step(1, 32'h00000033, 0, 0, 0, 0);
        check("x0.read", 193'(rd1E), 193'(0));

        // beq x0,x0,-4
        step(1, 32'hFE000EE3, 0, 0, 0, 0);
        check("beq.branch", 193'(branchE), 193'(1));
        check("beq.alu", 193'(aluControlE), 193'(1));
        check("beq.imm", 193'(immExtE), 193'(32'hFFFFFFFC));

        // flush with a valid instruction; writeback still lands in x7
        step(1, 32'h00500093, 1, 1, 7, 32'hCAFE0007);
        check("flush.all", obsVec, 193'(0));
        step(1, 32'h00038033, 0, 0, 0, 0);
        check("flush.write", 193'(rd1E), 193'(32'hCAFE0007));

        // illegal opcode
        step(1, 32'h0000007F, 0, 0, 0, 0);
        check("illegal.flag", 193'(illegalE), 193'(1));
        check("illegal.enables", 193'({regWriteE, memWriteE, branchE, jumpE, jalrE}),
              193'(0));

        // x5 written, then reset with flush and x5 write; x5 reads 0 after
        step(1, 32'h0, 0, 1, 5, 32'h55555555);
        step(0, 32'h00028033, 1, 1, 5, 32'h77777777);
        step(1, 32'h00028033, 0, 0, 0, 0);
        check("rst.x5", 193'(rd1E), 193'(0));

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 11);
            if (sel < 9) ins = {$urandom() & 32'hFFFFFF80} | 32'(opcs[sel]);
            else if (sel == 9) ins = 32'h0;
            else ins = $urandom();
            step(($urandom_range(0, 49) != 0), ins, ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 1) == 1, 5'($urandom()), $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 instrD  in  32  instruction from IF/ID register; 32'h0 marks a bubble.
REQ-005 pcD, pc4D  in  32 each  PC and PC+4 of instrD.
REQ-006 flushE  in  1  clears ID/EX register on next edge.
REQ-007 regWriteW  in  1  writeback enable.
REQ-008 rdW  in  5  writeback destination.
REQ-009 resultW  in  32  writeback data.
REQ-010 rs1D, rs2D  out  5 each  combinational instrD[19:15], instrD[24:20], for hazard unit.
REQ-011 regWriteE, memWriteE, branchE, jumpE, jalrE, aluSrcBE, illegalE  out  1 each  registered controls.
REQ-012 resultSrcE  out  2  registered: 00 ALU, 01 memory, 10 PC+4.
REQ-013 aluSrcAE  out  2  registered: 00 rd1, 01 PC, 10 zero.
REQ-014 aluControlE  out  4  registered ALU op; funct3E  out  3  registered instrD[14:12].
REQ-015 rd1E, rd2E, immExtE, pcE, pc4E  out  32 each  registered operands.
REQ-016 rs1E, rs2E, rdE  out  5 each  registered register indices.

Function
REQ-017 Register file: 32 x 32-bit; x0 reads 0; write at edge when regWriteW=1, rdW!=0, rst_n=1.
REQ-018 Reads combinational; if regWriteW=1, rdW==rsN, rsN!=0, read returns resultW (write-through bypass).
REQ-019 ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
REQ-020 R-type (0110011): regWrite, srcB=reg, ALU from funct3 plus funct7[5] (SUB, SRA).
REQ-021 I-ALU (0010011): regWrite, srcB=imm; funct7[5] selects SRA only for funct3=101; SUB never.
REQ-022 Load (0000011): regWrite, srcB=imm, resultSrc=01, ADD.
REQ-023 Store (0100011): memWrite, srcB=imm, ADD, regWrite=0.
REQ-024 Branch (1100011): branch, srcB=reg, SUB, regWrite=0.
REQ-025 JAL (1101111): jump, regWrite, resultSrc=10; JALR (1100111): jalr, regWrite, resultSrc=10, srcB=imm, ADD.
REQ-026 LUI (0110111): regWrite, srcA=10, srcB=imm, ADD; AUIPC (0010111): regWrite, srcA=01, srcB=imm, ADD.
REQ-027 Immediates sign-extended to 32 bits: I, S, B (bit0=0), U (low 12 zero), J (bit0=0); others 0.
REQ-028 Unlisted opcode: all enables 0, illegalE=1; instrD=32'h0: all enables 0, illegalE=0.
REQ-029 ID/EX register: latency one cycle; every E output equals decode of instrD sampled at previous edge.
REQ-030 flushE=1: all E outputs 0 next cycle (bubble); register-file write still performed.
REQ-031 No stall input; ID/EX loads every non-reset, non-flush cycle.

Reset
REQ-032 rst_n=0 at edge: all E outputs 0, all 32 registers 0, no register write; reset overrides flushE and regWriteW.
REQ-033 rs1D/rs2D remain combinational during reset.

Verification
REQ-034 Reset then instrD=32'h00500093 (addi x1,x0,5) -> next cycle regWriteE=1, aluSrcBE=1, immExtE=5, rdE=1, aluControlE=0000.
REQ-035 regWriteW=1, rdW=3, resultW=32'hDEADBEEF while instrD reads x3 -> rd1E=32'hDEADBEEF same pass; rdW=0 write -> x0 still reads 0.
REQ-036 instrD=32'hFE000EE3 (beq x0,x0,-4) -> branchE=1, aluControlE=0001, immExtE=32'hFFFFFFFC.
REQ-037 Valid instr with flushE=1 -> all E outputs 0; opcode 1111111 -> illegalE=1, all enables 0.
REQ-038 rst_n=0 with flushE=1 and regWriteW=1, rdW=5 -> outputs 0, x5 reads 0 after release.
